pic_sequencer: RTL and testbench
================================

PIC_SEQUENCER -- requirements
Module: pic_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_IMG, default 16, meaning the number of images stored on the card (range 2..256).
REQ-002 The block SHALL have parameter BLK_PER_IMG, default 300, meaning the number of 512-byte blocks per image (320x240 RGB565).
REQ-003 The block SHALL have parameter BASE_LBA, default 0, meaning the LBA of the first block of image 0.
REQ-004 The block SHALL have parameter AUTO_TICKS, default 50_000_000, meaning the number of clk cycles per slideshow interval.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port ctl_valid, input, 1 bit: a command from ctl_if is present.
REQ-008 The block SHALL have port ctl_ready, output, 1 bit: the sequencer accepts a command this cycle.
REQ-009 The block SHALL have ports ctl_incr and ctl_decr, input, 1 bit each: next-image and previous-image commands, qualified by ctl_valid.
REQ-010 The block SHALL have port auto_en, input, 1 bit: slideshow auto-advance enable.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: an image-load request to the SD reader.
REQ-012 The block SHALL have port rd_ready, input, 1 bit: the SD reader accepts the request.
REQ-013 The block SHALL have ports rd_lba (output, 32 bits) and rd_blk_cnt (output, 16 bits): start LBA and block count of the request.
REQ-014 The block SHALL have ports rd_done and rd_err, input, 1 bit each: single-cycle completion pulse and failure pulse from the SD reader.
REQ-015 The block SHALL have ports img_idx (output, 8 bits), busy (output, 1 bit) and err_flag (output, 1 bit): current image index, load in progress, and last load failed.

Function
REQ-016 The FSM SHALL have exactly four states: BOOT, IDLE, ISSUE, WAIT.
- BOOT: unconditional transition to ISSUE on the next cycle, which loads image 0 after reset.
REQ-017 In IDLE, ctl_ready=1; in every other state ctl_ready=0.
- A command is accepted when ctl_valid&ctl_ready.
REQ-018 On an accepted command with incr=1, decr=0:
- img_idx advances by 1 and wraps NUM_IMG-1 to 0.
- The FSM goes to ISSUE.
REQ-019 On an accepted command with decr=1, incr=0:
- img_idx steps back by 1 and wraps 0 to NUM_IMG-1.
- The FSM goes to ISSUE.
REQ-020 On an accepted command with incr=decr=1 or incr=decr=0, the command SHALL be consumed with no index change, and the FSM stays in IDLE.
REQ-021 The auto timer SHALL count only in IDLE with auto_en=1, and SHALL hold at 0 otherwise.
- On reaching AUTO_TICKS-1 it acts as an incr (REQ-018) and clears to 0.
REQ-022 If an accepted command and a timer expiry occur in the same cycle, the command SHALL win, the expiry is discarded, and the timer clears.
REQ-023 In ISSUE:
- rd_valid=1, rd_lba=BASE_LBA+img_idx*BLK_PER_IMG (32-bit unsigned, registered on ISSUE entry), and rd_blk_cnt=BLK_PER_IMG.
- These outputs stay stable until rd_valid&rd_ready, after which the FSM goes to WAIT.
REQ-024 rd_valid SHALL assert in the cycle after command acceptance: one-cycle latency from acceptance to request.
REQ-025 In WAIT:
- rd_done leads to IDLE with err_flag cleared.
- rd_err leads to IDLE with err_flag set, and img_idx is retained.
- If both pulse in the same cycle, rd_err wins.
REQ-026 busy SHALL be 1 in BOOT, ISSUE and WAIT, and 0 in IDLE.
REQ-027 rd_done and rd_err outside WAIT SHALL be ignored.

Reset
REQ-028 While rst=1, the block SHALL set: state=BOOT, img_idx=0, timer=0, err_flag=0, rd_valid=0, rd_lba=0, rd_blk_cnt=0, ctl_ready=0, busy=1.
REQ-029 Reset asserted mid-ISSUE or mid-WAIT SHALL abandon the request, with rd_valid low in the next cycle, and restart from BOOT (reload of image 0).

Structure
REQ-030 The state enum and the default parameter constants SHALL live in the shared package pic_pkg.
REQ-031 The slideshow timer SHALL be the sub-module tick_timer (ports: clk, rst, en, clr, expire).
- All remaining logic stays in a single FSM inside pic_sequencer.

Verification
REQ-032 Reset release -> rd_valid=1 within 2 cycles with rd_lba=0 and rd_blk_cnt=300; rd_ready=1 then rd_done -> IDLE, ctl_ready=1, img_idx=0.
REQ-033 idx=15, incr accepted -> img_idx=0 and rd_lba=0; then idx=0, decr accepted -> img_idx=15 and rd_lba=4500.
REQ-034 ctl_valid held with incr=1 while busy -> ctl_ready=0 and no index change until IDLE; the command is then taken exactly once.
REQ-035 AUTO_TICKS=8, auto_en=1 in IDLE -> request issued 8 cycles after IDLE entry; an incr command in the expiry cycle -> exactly one advance.
REQ-036 rd_err in WAIT -> err_flag=1 and idx unchanged; next successful rd_done -> err_flag=0.
REQ-037 rst=1 during WAIT with rd_ready stalled -> rd_valid drops next cycle; after release, reload of image 0 (rd_lba=0).

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and default constants for the picture-frame image sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pic_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int          DEF_NUM_IMG     = 16;
    localparam int          DEF_BLK_PER_IMG = 300;
    localparam int unsigned DEF_BASE_LBA    = 32'd0;
    localparam int          DEF_AUTO_TICKS  = 50_000_000;

    // Start LBA of an image: base + idx * blocks_per_image, wrapping in 32 bits.
    function automatic logic [31:0] img_lba(input logic [31:0] base,
                                            input logic [7:0]  idx,
                                            input logic [15:0] blk);
        return base + (32'(idx) * 32'(blk));
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Slideshow interval counter: pulses expire on the last tick of each interval.
// Latency: expire is combinational on the final count; the counter restarts next cycle.
// Backpressure: none; the counter holds at 0 whenever en is low or clr is high.
module tick_timer
    import pic_pkg::*;
#(
    parameter int TICKS = DEF_AUTO_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int            CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count;

    assign expire = en && (count == LAST);

    // Count enabled cycles; restart at 0 on clear, disable or expiry.
    always_ff @(posedge clk) begin
        if (rst || clr || !en || expire) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/pic_sequencer.sv
// Picks the image to show and issues block-read requests for it to the SD reader.
// Latency: read request one cycle after a command is accepted (two cycles after reset).
// Backpressure: commands accepted only in IDLE; request held stable until rd_ready.
module pic_sequencer
    import pic_pkg::*;
#(
    parameter int          NUM_IMG     = DEF_NUM_IMG,
    parameter int          BLK_PER_IMG = DEF_BLK_PER_IMG,
    parameter int unsigned BASE_LBA    = DEF_BASE_LBA,
    parameter int          AUTO_TICKS  = DEF_AUTO_TICKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctl_valid,
    output logic        ctl_ready,
    input  logic        ctl_incr,
    input  logic        ctl_decr,
    input  logic        auto_en,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_lba,
    output logic [15:0] rd_blk_cnt,
    input  logic        rd_done,
    input  logic        rd_err,
    output logic [7:0]  img_idx,
    output logic        busy,
    output logic        err_flag
);

    localparam logic [7:0]  IDX_MAX = 8'(NUM_IMG - 1);
    localparam logic [15:0] BLK_CNT = 16'(BLK_PER_IMG);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] idx_nxt;
    logic [7:0] idx_inc;
    logic [7:0] idx_dec;
    logic       err_nxt;
    logic       load;
    logic       accept;
    logic       timer_en;
    logic       expire;

    assign ctl_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rd_valid  = (state == ISSUE);
    assign accept    = ctl_valid && ctl_ready;
    assign timer_en  = (state == IDLE) && auto_en;

    assign idx_inc = (img_idx == IDX_MAX) ? 8'd0 : img_idx + 8'd1;
    assign idx_dec = (img_idx == 8'd0) ? IDX_MAX : img_idx - 8'd1;

    // An accepted command also clears the timer, so a same-cycle expiry is dropped.
    tick_timer #(
        .TICKS (AUTO_TICKS)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (timer_en),
        .clr    (accept),
        .expire (expire)
    );

    // Next-state, next index and error flag; load marks entry into ISSUE.
    always_comb begin
        state_nxt = state;
        idx_nxt   = img_idx;
        err_nxt   = err_flag;
        load      = 1'b0;
        case (state)
            BOOT: begin
                idx_nxt   = 8'd0;
                state_nxt = ISSUE;
                load      = 1'b1;
            end
            IDLE: begin
                if (accept) begin
                    if (ctl_incr && !ctl_decr) begin
                        idx_nxt   = idx_inc;
                        state_nxt = ISSUE;
                        load      = 1'b1;
                    end else if (ctl_decr && !ctl_incr) begin
                        idx_nxt   = idx_dec;
                        state_nxt = ISSUE;
                        load      = 1'b1;
                    end
                end else if (expire) begin
                    idx_nxt   = idx_inc;
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                if (rd_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (rd_err) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (rd_done) begin
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State, index and flag registers; request fields latched on ISSUE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            img_idx    <= 8'd0;
            err_flag   <= 1'b0;
            rd_lba     <= 32'd0;
            rd_blk_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            img_idx  <= idx_nxt;
            err_flag <= err_nxt;
            if (load) begin
                rd_lba     <= img_lba(BASE_LBA, idx_nxt, BLK_CNT);
                rd_blk_cnt <= BLK_CNT;
            end
        end
    end

endmodule

// File: tb/tb_pic_sequencer.sv
// Directed self-checking bench for pic_sequencer (16 images, 300 blocks, 8-tick slideshow).
// Inputs driven and outputs checked on the falling edge.
// Per-row expectations describe the state before that row's inputs take effect.
module tb_pic_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctl_valid, ctl_ready, ctl_incr, ctl_decr, auto_en;
    logic        rd_valid, rd_ready, rd_done, rd_err;
    logic [31:0] rd_lba;
    logic [15:0] rd_blk_cnt;
    logic [7:0]  img_idx;
    logic        busy, err_flag;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pic_sequencer #(
        .NUM_IMG     (16),
        .BLK_PER_IMG (300),
        .BASE_LBA    (0),
        .AUTO_TICKS  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctl_valid  (ctl_valid),
        .ctl_ready  (ctl_ready),
        .ctl_incr   (ctl_incr),
        .ctl_decr   (ctl_decr),
        .auto_en    (auto_en),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_lba     (rd_lba),
        .rd_blk_cnt (rd_blk_cnt),
        .rd_done    (rd_done),
        .rd_err     (rd_err),
        .img_idx    (img_idx),
        .busy       (busy),
        .err_flag   (err_flag)
    );

    typedef struct {
        logic        rst, v, i, d, ae, rr, dn, er;
        logic        rv, cr, bz, ef;
        logic [7:0]  idx;
        logic [31:0] lba;
        logic [15:0] blk;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic r, v, i, d, ae, rr, dn, er,
                                input logic rv, cr, bz, ef,
                                input logic [7:0] idx, input logic [31:0] lba,
                                input logic [15:0] blk);
        vec_t t;
        t.rst = r; t.v = v; t.i = i; t.d = d; t.ae = ae; t.rr = rr; t.dn = dn; t.er = er;
        t.rv = rv; t.cr = cr; t.bz = bz; t.ef = ef; t.idx = idx; t.lba = lba; t.blk = blk;
        return t;
    endfunction

    function automatic logic [63:0] obs();
        return {4'd0, rd_valid, ctl_ready, busy, err_flag, img_idx, rd_lba, rd_blk_cnt};
    endfunction

    function automatic logic [63:0] pk(input logic rv, cr, bz, ef, input logic [7:0] idx,
                                       input logic [31:0] lba, input logic [15:0] blk);
        return {4'd0, rv, cr, bz, ef, idx, lba, blk};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic r, v, i, d, ae, rr, dn, er);
        rst = r; ctl_valid = v; ctl_incr = i; ctl_decr = d;
        auto_en = ae; rd_ready = rr; rd_done = dn; rd_err = er;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 rst v i d ae rr dn er   rv cr bz ef idx lba   blk
        tbl[0]  = mk(1, 0,0,0,0, 0,0,0,   0,0,1,0, 0,  0,    0);
        tbl[1]  = mk(0, 0,0,0,0, 0,0,0,   0,0,1,0, 0,  0,    0);
        tbl[2]  = mk(0, 0,0,0,0, 0,0,0,   1,0,1,0, 0,  0,    300);
        tbl[3]  = mk(0, 0,0,0,0, 1,0,0,   1,0,1,0, 0,  0,    300);
        tbl[4]  = mk(0, 0,0,0,0, 0,1,0,   0,0,1,0, 0,  0,    300);
        tbl[5]  = mk(0, 1,1,0,0, 0,0,0,   0,1,0,0, 0,  0,    300);
        tbl[6]  = mk(0, 0,0,0,0, 1,0,0,   1,0,1,0, 1,  300,  300);
        tbl[7]  = mk(0, 0,0,0,0, 0,1,0,   0,0,1,0, 1,  300,  300);
        tbl[8]  = mk(0, 1,1,1,0, 0,0,0,   0,1,0,0, 1,  300,  300);
        tbl[9]  = mk(0, 1,0,1,0, 0,0,0,   0,1,0,0, 1,  300,  300);
        tbl[10] = mk(0, 0,0,0,0, 1,0,0,   1,0,1,0, 0,  0,    300);
        tbl[11] = mk(0, 0,0,0,0, 0,0,1,   0,0,1,0, 0,  0,    300);
        tbl[12] = mk(0, 1,0,1,0, 0,0,0,   0,1,0,1, 0,  0,    300);
        tbl[13] = mk(0, 0,0,0,0, 1,1,0,   1,0,1,1, 15, 4500, 300);
        tbl[14] = mk(0, 0,0,0,0, 0,1,1,   0,0,1,1, 15, 4500, 300);
        tbl[15] = mk(0, 1,1,0,0, 0,0,0,   0,1,0,1, 15, 4500, 300);
        tbl[16] = mk(0, 0,0,0,0, 1,0,0,   1,0,1,1, 0,  0,    300);
        tbl[17] = mk(0, 0,0,0,0, 0,1,0,   0,0,1,1, 0,  0,    300);
        tbl[18] = mk(0, 1,0,0,0, 0,0,0,   0,1,0,0, 0,  0,    300);
        tbl[19] = mk(0, 0,0,0,0, 0,1,1,   0,1,0,0, 0,  0,    300);
        tbl[20] = mk(0, 0,0,0,0, 0,0,0,   0,1,0,0, 0,  0,    300);

        drv(1, 0,0,0,0, 0,0,0);
        repeat (2) @(posedge clk);

        // Reset, boot load, index wrap both ways, no-op commands, error handling.
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", k), obs(),
                pk(tbl[k].rv, tbl[k].cr, tbl[k].bz, tbl[k].ef, tbl[k].idx, tbl[k].lba, tbl[k].blk));
            drv(tbl[k].rst, tbl[k].v, tbl[k].i, tbl[k].d, tbl[k].ae, tbl[k].rr, tbl[k].dn, tbl[k].er);
        end

        // Command held while busy: taken once on entry, then again only in IDLE.
        @(negedge clk);
        drv(0, 1,1,0,0, 0,0,0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_issue", 64'({ctl_ready, rd_valid, img_idx}), 64'({1'b0, 1'b1, 8'd1}));
        end
        rd_ready = 1'b1;
        @(negedge clk);
        chk("hold_wait", 64'({ctl_ready, busy, img_idx}), 64'({1'b0, 1'b1, 8'd1}));
        rd_ready = 1'b0; rd_done = 1'b1;
        @(negedge clk);
        chk("hold_idle", 64'({ctl_ready, img_idx}), 64'({1'b1, 8'd1}));
        rd_done = 1'b0;
        @(negedge clk);
        chk("hold_taken", obs(), pk(1, 0, 1, 0, 2, 600, 300));
        drv(0, 0,0,0,0, 1,0,0);
        @(negedge clk);
        drv(0, 0,0,0,0, 0,1,0);
        @(negedge clk);
        drv(0, 0,0,0,0, 0,0,0);
        @(negedge clk);
        chk("hold_once", obs(), pk(0, 1, 0, 0, 2, 600, 300));

        // Slideshow: request issued 8 cycles after IDLE entry.
        drv(0, 1,1,0,0, 0,0,0);
        @(negedge clk);
        drv(0, 0,0,0,0, 1,0,0);
        @(negedge clk);
        drv(0, 0,0,0,1, 0,1,0);
        @(negedge clk);
        drv(0, 0,0,0,1, 0,0,0);
        chk("auto_entry", obs(), pk(0, 1, 0, 0, 3, 900, 300));
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("auto_wait%0d", k), 64'({rd_valid, ctl_ready}), 64'({1'b0, 1'b1}));
        end
        @(negedge clk);
        chk("auto_fire", obs(), pk(1, 0, 1, 0, 4, 1200, 300));

        // Command in the expiry cycle: exactly one advance.
        drv(0, 0,0,0,1, 1,0,0);
        @(negedge clk);
        drv(0, 0,0,0,1, 0,1,0);
        @(negedge clk);
        drv(0, 0,0,0,1, 0,0,0);
        for (int k = 1; k < 7; k++) @(negedge clk);
        @(negedge clk);
        drv(0, 1,1,0,1, 0,0,0);
        @(negedge clk);
        drv(0, 0,0,0,0, 0,0,0);
        chk("auto_collide", obs(), pk(1, 0, 1, 0, 5, 1500, 300));
        @(negedge clk);
        chk("auto_stall", obs(), pk(1, 0, 1, 0, 5, 1500, 300));

        // Reset during stalled ISSUE, then during WAIT: request abandoned, image 0 reloaded.
        rst = 1'b1;
        @(negedge clk);
        chk("rst_issue", obs(), pk(0, 0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_reload1", obs(), pk(1, 0, 1, 0, 0, 0, 300));
        rd_ready = 1'b1;
        @(negedge clk);
        chk("rst_wait_pre", 64'({rd_valid, busy}), 64'({1'b0, 1'b1}));
        rd_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_wait", obs(), pk(0, 0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_reload2", obs(), pk(1, 0, 1, 0, 0, 0, 300));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0; rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        chk("rst_final_idle", obs(), pk(0, 1, 0, 0, 0, 0, 300));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
